ctrl_sequencer: RTL and testbench
=================================

CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameters (name, default, meaning): IW, 9, instruction width, minimum 6; TSW, 2, target-select field width; MEM_TO, 15, memory-wait timeout in cycles, minimum 1.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 Clk  in  1  sole clock, rising edge.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 InstValid  in  1  fetch offers Instruction.
REQ-006 Instruction  in  IW  machine code; opcode = Instruction[IW-1:IW-3].
REQ-007 MemDone  in  1  data memory completes current access.
REQ-008 InstReady  out  1  sequencer accepts an instruction this cycle.
REQ-009 RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst, BranchEn  out  1 each  registered control strobes.
REQ-010 TargSel  out  TSW  LUT select = latched Instruction[IW-4 -: TSW].
REQ-011 Ack  out  1  program done, sticky.
REQ-012 MemErr  out  1  one-cycle pulse on memory timeout.

Function
REQ-013 FSM states: IDLE, EXEC, MEM, HALT; all outputs are registered and derive from state plus latched instruction.
REQ-014 IDLE: InstReady=1; a handshake (InstValid & InstReady) latches Instruction and moves to EXEC next cycle; without InstValid, stay in IDLE.
REQ-015 Instruction is sampled only on handshake; changes at other times are ignored.
REQ-016 All-ones instruction (halt) goes from IDLE to HALT, bypassing EXEC; HALT drives Ack=1 and InstReady=0 until Reset.
REQ-017 EXEC lasts exactly 1 cycle.
REQ-018 EXEC, ALU class (opcode[2:1] != 2'b11 and opcode != OP_LOAD): RegWrEn=1 for that cycle, then IDLE.
REQ-019 EXEC, OP_BRANCH (3'b110): BranchEn=1 for that cycle, RegWrEn=0, then IDLE.
REQ-020 EXEC, OP_LOAD (3'b011) or OP_STORE (3'b111, non-halt): go to MEM next cycle.
REQ-021 MEM, load: MemRdEn=1 and LoadInst=1, held until exit.
REQ-022 MEM, store: MemWrEn=1 and StoreInst=1, held until exit.
REQ-023 MEM: MemDone is sampled every cycle, including the first MEM cycle.
REQ-024 MEM exit on MemDone: for a load, RegWrEn=1 for exactly the cycle after MemDone, then IDLE; for a store, go to IDLE directly.
REQ-025 MEM timeout: a wait counter runs in MEM; when it reaches MEM_TO without MemDone, pulse MemErr for 1 cycle, return to IDLE, and suppress RegWrEn.
REQ-026 MEM throughput: a load with immediate MemDone is accepted-to-IDLE in 4 cycles; a store with immediate MemDone takes 3.
REQ-027 MemDone is ignored in IDLE, EXEC and HALT.
REQ-028 InstReady=0 in every state except IDLE; no instruction is accepted while busy.
REQ-029 TargSel holds the latched field from the handshake until the next handshake.

Reset
REQ-030 Reset high at a clock edge forces IDLE, clears the latched instruction, wait counter and Ack, and drives all strobes, TargSel and MemErr to 0 on the next cycle, from any state including MEM and HALT.
REQ-031 InstReady=1 in the first cycle after Reset deasserts.

Configuration
REQ-032 Macro CTRL_SEQ_PERF_EN adds outputs PerfInst (32-bit, counts handshakes) and PerfStall (32-bit, counts MEM cycles).
REQ-033 Both counters clear on Reset and saturate at all-ones.
REQ-034 Without CTRL_SEQ_PERF_EN, the ports and counters are absent and all other behaviour is identical.

Structure
REQ-035 Package ctrl_pkg holds: opcode constants OP_LOAD, OP_STORE, OP_BRANCH; the state enum typedef; and the halt-detect function.
REQ-036 Sub-module ctrl_op_class performs combinational opcode classification (alu/load/store/branch/halt) and is instantiated once.

Verification
REQ-037 Reset, then ALU instruction 9'b000_01_0101 with InstValid=1 -> EXEC next cycle with RegWrEn=1, TargSel=2'b01; InstReady=1 again 2 cycles after handshake.
REQ-038 Load 9'b011_10_0000, MemDone high 3 cycles after entering MEM -> MemRdEn=LoadInst=1 for 3 cycles, then RegWrEn=1 for 1 cycle, then IDLE.
REQ-039 Store 9'b111_00_0001 with MemDone held low, MEM_TO=15 -> MemWrEn=1 for 15 cycles, MemErr pulse, RegWrEn never asserted.
REQ-040 Halt 9'b1_1111_1111 -> Ack=1 and InstReady=0 indefinitely; Reset -> Ack=0 and InstReady=1 after release.
REQ-041 Reset asserted in the second MEM cycle of a load -> all strobes 0 the next cycle, no RegWrEn; with CTRL_SEQ_PERF_EN, PerfInst=0 and PerfStall=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the control sequencer: opcode constants, FSM state
// encoding, opcode-class payload and the halt-detect helper.
package ctrl_pkg;

    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_STORE  = 3'b111;
    localparam logic [2:0] OP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic halt;
    } op_kind_t;

    // True when the low iw bits of inst are all ones.
    function automatic logic is_halt(input logic [63:0] inst, input int unsigned iw);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < iw) r = r & inst[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Fetch/memory-facing signal bundle of ctrl_sequencer.
// CTRL_SEQ_PERF_EN adds the PerfInst/PerfStall counter outputs.
interface ctrl_sequencer_if #(
    parameter int unsigned IW  = 9,
    parameter int unsigned TSW = 2
);
    logic           InstValid;
    logic [IW-1:0]  Instruction;
    logic           MemDone;
    logic           InstReady;
    logic           RegWrEn;
    logic           MemWrEn;
    logic           MemRdEn;
    logic           LoadInst;
    logic           StoreInst;
    logic           BranchEn;
    logic [TSW-1:0] TargSel;
    logic           Ack;
    logic           MemErr;
`ifdef CTRL_SEQ_PERF_EN
    logic [31:0]    PerfInst;
    logic [31:0]    PerfStall;

    modport master (
        output InstValid, Instruction, MemDone,
        input  InstReady, RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst,
               BranchEn, TargSel, Ack, MemErr, PerfInst, PerfStall
    );
    modport slave (
        input  InstValid, Instruction, MemDone,
        output InstReady, RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst,
               BranchEn, TargSel, Ack, MemErr, PerfInst, PerfStall
    );
`else
    modport master (
        output InstValid, Instruction, MemDone,
        input  InstReady, RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst,
               BranchEn, TargSel, Ack, MemErr
    );
    modport slave (
        input  InstValid, Instruction, MemDone,
        output InstReady, RegWrEn, MemWrEn, MemRdEn, LoadInst, StoreInst,
               BranchEn, TargSel, Ack, MemErr
    );
`endif
endinterface

// File: rtl/ctrl_op_class.sv
// Combinational opcode classifier: alu / load / store / branch / halt.
module ctrl_op_class
    import ctrl_pkg::*;
#(
    parameter int unsigned IW = 9
) (
    input  logic [IW-1:0] inst_i,
    output op_kind_t      kind_c_o
);

    logic [2:0] op;
    assign op = inst_i[IW-1 -: 3];

    // Halt shares the store opcode, so it is excluded from the store class.
    always_comb begin
        kind_c_o        = '0;
        kind_c_o.halt   = is_halt(64'(inst_i), IW);
        kind_c_o.load   = (op == OP_LOAD);
        kind_c_o.store  = (op == OP_STORE) && !kind_c_o.halt;
        kind_c_o.branch = (op == OP_BRANCH);
        kind_c_o.alu    = (op[2:1] != 2'b11) && (op != OP_LOAD);
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Instruction sequencer FSM (IDLE/EXEC/MEM/HALT) driving registered control strobes.
// Optional feature macro: CTRL_SEQ_PERF_EN (handshake and MEM-stall counters).
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned IW     = 9,
    parameter int unsigned TSW    = 2,
    parameter int unsigned MEM_TO = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    ctrl_sequencer_if.slave   bus
);

    localparam int unsigned WW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;

    state_e         state_q, state_d;
    logic [IW-1:0]  inst_q, inst_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic           wb_q, wb_d;

    logic           rdy_q, rdy_d;
    logic           regwr_q, regwr_d;
    logic           memwr_q, memwr_d;
    logic           memrd_q, memrd_d;
    logic           ld_q, ld_d;
    logic           st_q, st_d;
    logic           br_q, br_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [TSW-1:0] targ_q, targ_d;

    logic           hs;
    logic [IW-1:0]  cls_inst;
    op_kind_t       kind;

    assign hs = bus.InstValid && rdy_q;

    // In IDLE the incoming word is classified so EXEC strobes can be registered
    // at the handshake edge; afterwards the latched word drives decisions.
    assign cls_inst = (state_q == ST_IDLE) ? bus.Instruction : inst_q;

    ctrl_op_class #(.IW(IW)) u_op_class (
        .inst_i   (cls_inst),
        .kind_c_o (kind)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        wait_d  = wait_q;
        wb_d    = 1'b0;
        regwr_d = 1'b0;
        memwr_d = 1'b0;
        memrd_d = 1'b0;
        ld_d    = 1'b0;
        st_d    = 1'b0;
        br_d    = 1'b0;
        err_d   = 1'b0;
        ack_d   = ack_q;
        targ_d  = targ_q;

        unique case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    inst_d = bus.Instruction;
                    targ_d = bus.Instruction[IW-4 -: TSW];
                    if (kind.halt) begin
                        state_d = ST_HALT;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                        regwr_d = kind.alu;
                        br_d    = kind.branch;
                    end
                end
            end

            ST_EXEC: begin
                if (kind.load || kind.store) begin
                    state_d = ST_MEM;
                    wait_d  = '0;
                    memrd_d = kind.load;
                    ld_d    = kind.load;
                    memwr_d = kind.store;
                    st_d    = kind.store;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            // wb_q marks the load write-back cycle that follows MemDone.
            ST_MEM: begin
                if (wb_q) begin
                    state_d = ST_IDLE;
                end else if (bus.MemDone) begin
                    if (kind.load) begin
                        wb_d    = 1'b1;
                        regwr_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wait_q == WW'(MEM_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q + WW'(1);
                    memrd_d = kind.load;
                    ld_d    = kind.load;
                    memwr_d = kind.store;
                    st_d    = kind.store;
                end
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_IDLE;
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            wait_q  <= '0;
            wb_q    <= 1'b0;
            rdy_q   <= 1'b1;
            regwr_q <= 1'b0;
            memwr_q <= 1'b0;
            memrd_q <= 1'b0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            br_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            targ_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            wait_q  <= wait_d;
            wb_q    <= wb_d;
            rdy_q   <= rdy_d;
            regwr_q <= regwr_d;
            memwr_q <= memwr_d;
            memrd_q <= memrd_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            br_q    <= br_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            targ_q  <= targ_d;
        end
    end

    assign bus.InstReady = rdy_q;
    assign bus.RegWrEn   = regwr_q;
    assign bus.MemWrEn   = memwr_q;
    assign bus.MemRdEn   = memrd_q;
    assign bus.LoadInst  = ld_q;
    assign bus.StoreInst = st_q;
    assign bus.BranchEn  = br_q;
    assign bus.Ack       = ack_q;
    assign bus.MemErr    = err_q;
    assign bus.TargSel   = targ_q;

`ifdef CTRL_SEQ_PERF_EN
    logic [31:0] perf_inst_q;
    logic [31:0] perf_stall_q;

    // Saturating counters: handshakes and MEM wait cycles (write-back excluded).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            perf_inst_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (hs && !(&perf_inst_q)) perf_inst_q <= perf_inst_q + 32'd1;
            if ((state_q == ST_MEM) && !wb_q && !(&perf_stall_q))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign bus.PerfInst  = perf_inst_q;
    assign bus.PerfStall = perf_stall_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed and random transactions
// compared cycle by cycle against a transaction-level expected-trace model.
module tb_ctrl_sequencer;

    localparam int unsigned IW     = 9;
    localparam int unsigned TSW    = 2;
    localparam int unsigned MEM_TO = 15;
    localparam int unsigned VW     = 9 + TSW;

    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ctrl_sequencer_if #(.IW(IW), .TSW(TSW)) bus ();

    ctrl_sequencer #(.IW(IW), .TSW(TSW), .MEM_TO(MEM_TO)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int exp_hs = 0;
    int exp_stall = 0;
    logic [TSW-1:0] last_targ = '0;
    vec_t exp_q[$];
    int nmem_g;

    // Field order: rdy regwr memwr memrd ld st br ack err targ
    function automatic vec_t mk(input logic rdy, input logic regwr, input logic memwr,
                                input logic memrd, input logic ld, input logic st,
                                input logic br, input logic ack, input logic err,
                                input logic [TSW-1:0] targ);
        return {rdy, regwr, memwr, memrd, ld, st, br, ack, err, targ};
    endfunction

    function automatic vec_t obs();
        return {bus.InstReady, bus.RegWrEn, bus.MemWrEn, bus.MemRdEn, bus.LoadInst,
                bus.StoreInst, bus.BranchEn, bus.Ack, bus.MemErr, bus.TargSel};
    endfunction

    task automatic check(input string tag, input vec_t e);
        vec_t o;
        o = obs();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (rdy,regwr,memwr,memrd,ld,st,br,ack,err,targ)",
                   tag, o, e);
        end
    endtask

`ifdef CTRL_SEQ_PERF_EN
    task automatic check32(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask
`endif

    // Expected per-cycle outputs after a handshake, derived from the instruction
    // class and the MEM cycle (0-based) in which MemDone is offered (<0: never).
    task automatic build_exp(input logic [IW-1:0] ins, input int done_at);
        logic [2:0]     op;
        logic [TSW-1:0] ts;
        logic           is_ld, is_st;
        bit             done;
        op     = ins[IW-1 -: 3];
        ts     = ins[IW-4 -: TSW];
        is_ld  = (op == 3'b011);
        is_st  = (op == 3'b111);
        nmem_g = 0;
        exp_q.delete();
        if (is_ld || is_st) begin
            done = (done_at >= 0) && (done_at < int'(MEM_TO));
            nmem_g = done ? done_at + 1 : int'(MEM_TO);
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ts));
            for (int k = 0; k < nmem_g; k++)
                exp_q.push_back(mk(0, 0, is_st, is_ld, is_ld, is_st, 0, 0, 0, ts));
            if (done && is_ld) exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, ts));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, !done, ts));
        end else if (op == 3'b110) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, ts));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ts));
        end else begin
            exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, ts));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, ts));
        end
    endtask

    task automatic handshake(input string tag, input logic [IW-1:0] ins);
        @(posedge clk); #1;
        bus.InstValid   = 1'b1;
        bus.Instruction = ins;
        bus.MemDone     = 1'($urandom);
        @(negedge clk);
        check({tag, ":hs"}, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, last_targ));
    endtask

    // Busy-cycle inputs are randomised: InstValid/Instruction must be ignored and
    // MemDone only matters inside the MEM window.
    task automatic drive_busy(input int i, input int done_at, input bit last);
        bus.InstValid   = last ? 1'b0 : 1'($urandom);
        bus.Instruction = IW'($urandom);
        if (i >= 1 && i <= nmem_g) bus.MemDone = ((i - 1) == done_at);
        else                       bus.MemDone = 1'($urandom);
    endtask

    task automatic run_txn(input string tag, input logic [IW-1:0] ins, input int done_at);
        build_exp(ins, done_at);
        handshake(tag, ins);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            drive_busy(i, done_at, i == exp_q.size() - 1);
            @(negedge clk);
            check($sformatf("%s[%0d]", tag, i), exp_q[i]);
        end
        exp_hs++;
        exp_stall += nmem_g;
        last_targ = ins[IW-4 -: TSW];
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.InstValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        last_targ = '0;
        exp_hs    = 0;
        exp_stall = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] ins;
        int            d;

        rst             = 1'b1;
        bus.InstValid   = 1'b0;
        bus.Instruction = '0;
        bus.MemDone     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_held", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0));

        run_txn("alu",         9'b000_01_0101, -1);
        run_txn("branch",      9'b110_11_0011, 0);
        run_txn("load_d2",     9'b011_10_0000, 2);
        run_txn("store_to",    9'b111_00_0001, -1);
        run_txn("load_d0",     9'b011_01_1010, 0);
        run_txn("store_d0",    9'b111_10_0110, 0);
        run_txn("load_to",     9'b011_11_0001, -1);
        run_txn("store_last",  9'b111_01_0000, int'(MEM_TO) - 1);
        run_txn("load_late",   9'b011_00_1111, int'(MEM_TO));
        run_txn("alu_101",     9'b101_10_1111, 3);

`ifdef CTRL_SEQ_PERF_EN
        check32("perf_inst_dir", bus.PerfInst, 32'(exp_hs));
        check32("perf_stall_dir", bus.PerfStall, 32'(exp_stall));
`endif

        for (int n = 0; n < 40; n++) begin
            ins = IW'($urandom);
            if (&ins) ins[0] = 1'b0;
            d = int'($urandom_range(0, 19)) - 2;
            run_txn($sformatf("rnd%0d", n), ins, d);
        end

`ifdef CTRL_SEQ_PERF_EN
        check32("perf_inst_rnd", bus.PerfInst, 32'(exp_hs));
        check32("perf_stall_rnd", bus.PerfStall, 32'(exp_stall));
`endif

        // Halt: sticky Ack, no further acceptance until reset.
        handshake("halt", '1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            bus.InstValid   = 1'($urandom);
            bus.Instruction = IW'($urandom);
            bus.MemDone     = 1'($urandom);
            @(negedge clk);
            check($sformatf("halt[%0d]", i), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, '1));
        end
        pulse_reset();
        check("halt_reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        run_txn("post_halt_alu", 9'b010_11_0000, -1);

        // Reset in the second MEM cycle of a load.
        build_exp(9'b011_10_0000, -1);
        handshake("rst_mem", 9'b011_10_0000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive_busy(i, -1, 1'b0);
            if (i == 2) begin
                rst = 1'b1;
                bus.InstValid = 1'b0;
            end
            @(negedge clk);
            check($sformatf("rst_mem[%0d]", i), exp_q[i]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.MemDone = 1'b1;
        @(negedge clk);
        check("rst_mem_after", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0));
`ifdef CTRL_SEQ_PERF_EN
        check32("rst_mem_perf_inst", bus.PerfInst, 32'd0);
        check32("rst_mem_perf_stall", bus.PerfStall, 32'd0);
`endif
        @(posedge clk); #1;
        bus.MemDone = 1'b0;
        @(negedge clk);
        check("rst_mem_idle", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        last_targ = '0;
        run_txn("post_rst_store", 9'b111_11_0101, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
